bw_dtl_impctl_sched: RTL

BW_DTL_IMPCTL_SCHED -- requirements
Module: bw_dtl_impctl_sched

---
 rtl/bw_dtl_impctl_sched.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bw_dtl_impctl_sched.sv
// Impedance-calibration scheduler: round-robin grant of one shared comparator to the
// pulldown/pullup units, counter reset, settle, deltabit sampling and one update strobe.
module bw_dtl_impctl_sched #(
  parameter int SETTLE_CYC = 16,
  parameter int SAMPLE_CYC = 64
) (
  input  logic       rclk,
  input  logic       reset,
  input  logic       cal_en,
  input  logic [1:0] req,
  input  logic [1:0] deltabit,
  input  logic       we_csr,
  output logic [1:0] gnt,
  output logic       avgcntr_rst,
  output logic [1:0] upd_pulse,
  output logic       upd_dir,
  output logic [7:0] above_cnt,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RST_AVG = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_SAMPLE  = 3'd3;
  localparam logic [2:0] ST_UPDATE  = 3'd4;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYC - 1);
  localparam logic [7:0] HALF_CNT    = 8'(SAMPLE_CYC / 2);

  // Handshake: req is a level request; a window is granted from IDLE when cal_en=1,
  // we_csr=0 and req!=0, and gnt is the acknowledgement held until the window ends.

  logic [2:0] state;
  logic [7:0] tmr;
  logic [7:0] cnt;
  logic       last_unit;  // 1 = pullup (bit1) completed the most recent window
  logic [1:0] pick_gnt;
  logic       grant_ok;
  logic       sample_bit;
  logic [7:0] cnt_fin;

  always_comb begin
    pick_gnt = 2'b00;
    case (req)
      2'b01:   pick_gnt = 2'b01;
      2'b10:   pick_gnt = 2'b10;
      2'b11:   pick_gnt = last_unit ? 2'b01 : 2'b10;
      default: pick_gnt = 2'b00;
    endcase
  end

  assign grant_ok   = cal_en & ~we_csr & (req != 2'b00);
  assign sample_bit = |(deltabit & gnt);
  assign cnt_fin    = cnt + {7'b0, sample_bit};
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge rclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      gnt         <= 2'b00;
      avgcntr_rst <= 1'b0;
      upd_pulse   <= 2'b00;
      upd_dir     <= 1'b0;
      above_cnt   <= 8'd0;
      last_unit   <= 1'b1;
      tmr         <= 8'd0;
      cnt         <= 8'd0;
    end else begin
      avgcntr_rst <= 1'b0;
      upd_pulse   <= 2'b00;
      if (state != ST_IDLE && we_csr) begin
        // CSR write abandons the window without touching results or the pointer
        state <= ST_IDLE;
        gnt   <= 2'b00;
      end else begin
        case (state)
          ST_IDLE: begin
            if (grant_ok) begin
              state       <= ST_RST_AVG;
              gnt         <= pick_gnt;
              avgcntr_rst <= 1'b1;
              cnt         <= 8'd0;
            end
          end
          ST_RST_AVG: begin
            state <= ST_SETTLE;
            tmr   <= SETTLE_LAST;
          end
          ST_SETTLE: begin
            if (tmr == 8'd0) begin
              state <= ST_SAMPLE;
              tmr   <= SAMPLE_LAST;
            end else begin
              tmr <= tmr - 8'd1;
            end
          end
          ST_SAMPLE: begin
            cnt <= cnt_fin;
            if (tmr == 8'd0) begin
              // Results and strobe are registered so they appear during UPDATE
              state     <= ST_UPDATE;
              upd_pulse <= gnt;
              above_cnt <= cnt_fin;
              upd_dir   <= (cnt_fin > HALF_CNT);
              last_unit <= gnt[1];
            end else begin
              tmr <= tmr - 8'd1;
            end
          end
          ST_UPDATE: begin
            state <= ST_IDLE;
            gnt   <= 2'b00;
          end
          default: begin
            state <= ST_IDLE;
            gnt   <= 2'b00;
          end
        endcase
      end
    end
  end

endmodule
